// File: rtl/memory_arbiter.sv
// Two-port block memory arbiter: I-cache (read-only) and D-cache (read/write)
// share one block memory, round-robin on contention, with an access timeout.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT,
    output logic                  ERROR
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS_I,
        ACCESS_D,
        DONE_I,
        DONE_D
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(WAIT_LIMIT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       last_grant_d;
    logic       op_write;
    logic       i_req;
    logic       d_req;
    logic       grant_d;

    assign i_req = I_READ;
    assign d_req = D_READ | D_WRITE;

    // D wins when alone or when I was served last; otherwise I gets the slot.
    assign grant_d = d_req & (~i_req | ~last_grant_d);

    assign I_BUSYWAIT = i_req & (state != DONE_I);
    assign D_BUSYWAIT = d_req & (state != DONE_D);

    // NOTE: every register below is updated with <= so all branches see pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            last_grant_d  <= 1'b0;
            op_write      <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            I_READDATA    <= '0;
            D_READDATA    <= '0;
            ERROR         <= 1'b0;
        end else begin
            ERROR <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state         <= ACCESS_D;
                        last_grant_d  <= 1'b1;
                        wait_cnt      <= '0;
                        MEM_ADDRESS   <= D_ADDRESS;
                        MEM_WRITEDATA <= D_WRITEDATA;
                        // A simultaneous read and write is served as the write-back.
                        op_write      <= D_WRITE;
                        MEM_WRITE     <= D_WRITE;
                        MEM_READ      <= ~D_WRITE;
                    end else if (i_req) begin
                        state        <= ACCESS_I;
                        last_grant_d <= 1'b0;
                        wait_cnt     <= '0;
                        MEM_ADDRESS  <= I_ADDRESS;
                        op_write     <= 1'b0;
                        MEM_WRITE    <= 1'b0;
                        MEM_READ     <= 1'b1;
                    end
                end
                ACCESS_I, ACCESS_D: begin
                    if (!MEM_BUSYWAIT) begin
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        if (state == ACCESS_I) begin
                            I_READDATA <= MEM_READDATA;
                            state      <= DONE_I;
                        end else begin
                            if (!op_write) begin
                                D_READDATA <= MEM_READDATA;
                            end
                            state <= DONE_D;
                        end
                    end else if (wait_cnt == LAST_WAIT) begin
                        // Timeout: abandon the access and hand the requester a zero block.
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        ERROR     <= 1'b1;
                        if (state == ACCESS_I) begin
                            I_READDATA <= '0;
                            state      <= DONE_I;
                        end else begin
                            D_READDATA <= '0;
                            state      <= DONE_D;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a 5-cycle-busy block memory model.
module tb_memory_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          I_READ;
    logic [AW-1:0] I_ADDRESS;
    logic [DW-1:0] I_READDATA;
    logic          I_BUSYWAIT;
    logic          D_READ;
    logic          D_WRITE;
    logic [AW-1:0] D_ADDRESS;
    logic [DW-1:0] D_WRITEDATA;
    logic [DW-1:0] D_READDATA;
    logic          D_BUSYWAIT;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [AW-1:0] MEM_ADDRESS;
    logic [DW-1:0] MEM_WRITEDATA;
    logic [DW-1:0] MEM_READDATA;
    logic          MEM_BUSYWAIT;
    logic          ERROR;

    memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_LIMIT(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    // Memory model: busy for 5 cycles after a strobe rises, optional stuck-busy.
    logic [DW-1:0] mem_model [16];
    int            mem_cnt;
    logic          stuck;
    logic          pre_we;
    logic [3:0]    pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < 16; i++) mem_model[i] <= '0;
            mem_cnt <= 0;
        end else begin
            mem_cnt <= (MEM_READ | MEM_WRITE) ? mem_cnt + 1 : 0;
            if (pre_we) mem_model[pre_addr] <= pre_data;
            else if (MEM_WRITE && !MEM_BUSYWAIT) mem_model[MEM_ADDRESS[3:0]] <= MEM_WRITEDATA;
        end
    end

    assign MEM_BUSYWAIT = stuck | ((MEM_READ | MEM_WRITE) && (mem_cnt < 5));
    assign MEM_READDATA = mem_model[MEM_ADDRESS[3:0]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for the requester's BUSYWAIT to fall; returns posedges taken.
    task automatic wait_done(input bit is_i, output int cycles);
        cycles = 0;
        do begin
            @(posedge CLK);
            cycles++;
            @(negedge CLK);
        end while ((is_i ? I_BUSYWAIT : D_BUSYWAIT) && cycles < 40);
        if (is_i ? I_BUSYWAIT : D_BUSYWAIT) begin
            n_checks++;
            n_errors++;
            $display("FAIL busywait_timeout: still high after %0d cycles, required low", cycles);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    typedef enum logic [1:0] {OP_IRD, OP_DRD, OP_DWR, OP_DBOTH} op_e;

    typedef struct {
        op_e           op;
        logic          pre;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    localparam logic [DW-1:0] W1 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    localparam logic [DW-1:0] W2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;

    vec_t          vecs [8];
    logic [DW-1:0] exp_d_rd;

    task automatic run_vec(input int idx, input vec_t v);
        bit is_i;
        bit is_wr;
        int cyc;
        is_i  = (v.op == OP_IRD);
        is_wr = (v.op == OP_DWR) || (v.op == OP_DBOTH);
        if (v.pre) preload(v.addr[3:0], v.data);
        I_READ      = is_i;
        D_READ      = (v.op == OP_DRD) || (v.op == OP_DBOTH);
        D_WRITE     = is_wr;
        I_ADDRESS   = v.addr;
        D_ADDRESS   = v.addr;
        D_WRITEDATA = v.data;
        @(posedge CLK);
        @(negedge CLK);
        check($sformatf("v%0d_mem_read", idx), MEM_READ, !is_wr);
        check($sformatf("v%0d_mem_write", idx), MEM_WRITE, is_wr);
        check($sformatf("v%0d_mem_addr", idx), MEM_ADDRESS, v.addr);
        if (is_wr) check($sformatf("v%0d_mem_wdata", idx), MEM_WRITEDATA, v.data);
        wait_done(is_i, cyc);
        check($sformatf("v%0d_latency", idx), DW'(cyc), DW'(6));
        check($sformatf("v%0d_strobes_low", idx), {MEM_READ, MEM_WRITE}, 2'b00);
        check($sformatf("v%0d_error", idx), ERROR, 1'b0);
        if (is_i) begin
            check($sformatf("v%0d_i_rdata", idx), I_READDATA, v.data);
        end else if (is_wr) begin
            check($sformatf("v%0d_d_rdata_kept", idx), D_READDATA, exp_d_rd);
            check($sformatf("v%0d_mem_content", idx), mem_model[v.addr[3:0]], v.data);
        end else begin
            check($sformatf("v%0d_d_rdata", idx), D_READDATA, v.data);
            exp_d_rd = v.data;
        end
        // Request still held one more cycle: BUSYWAIT must already be high again.
        @(posedge CLK);
        @(negedge CLK);
        check($sformatf("v%0d_busy_again", idx), is_i ? I_BUSYWAIT : D_BUSYWAIT, 1'b1);
        I_READ  = 1'b0;
        D_READ  = 1'b0;
        D_WRITE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        vecs[0] = '{OP_IRD,   1'b1, 28'h4, {16{8'hA5}}};
        vecs[1] = '{OP_DRD,   1'b1, 28'h5, {16{8'h5A}}};
        vecs[2] = '{OP_DWR,   1'b0, 28'h7, W1};
        vecs[3] = '{OP_DRD,   1'b0, 28'h7, W1};
        vecs[4] = '{OP_IRD,   1'b0, 28'h7, W1};
        vecs[5] = '{OP_DBOTH, 1'b0, 28'h3, W2};
        vecs[6] = '{OP_IRD,   1'b0, 28'h3, W2};
        vecs[7] = '{OP_DRD,   1'b1, 28'h0, {DW{1'b1}}};

        RESET = 1'b0; I_READ = 1'b1; I_ADDRESS = 28'h10;
        D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
        stuck = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        exp_d_rd = '0;

        // Reset held two cycles with an I request pending.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_strobes", {MEM_READ, MEM_WRITE, ERROR}, 3'b000);
        check("rst_mem_addr", MEM_ADDRESS, '0);
        check("rst_mem_wdata", MEM_WRITEDATA, '0);
        check("rst_i_rdata", I_READDATA, '0);
        check("rst_d_rdata", D_READDATA, '0);
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("rel_mem_read", MEM_READ, 1'b1);
        check("rel_mem_addr", MEM_ADDRESS, 28'h10);
        check("rel_i_busy", I_BUSYWAIT, 1'b1);
        wait_done(1'b1, cyc);
        check("rel_latency", DW'(cyc), DW'(6));
        check("rel_i_rdata", I_READDATA, '0);
        I_READ = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Contention after reset: D write first, then alternation I, D.
        do_reset();
        exp_d_rd = '0;
        preload(4'h8, {8{16'hBEEF}});
        I_READ = 1'b1; I_ADDRESS = 28'h8;
        D_WRITE = 1'b1; D_ADDRESS = 28'h3; D_WRITEDATA = W1;
        @(posedge CLK);
        @(negedge CLK);
        check("arb1_mem_write", {MEM_WRITE, MEM_READ}, 2'b10);
        check("arb1_mem_addr", MEM_ADDRESS, 28'h3);
        wait_done(1'b0, cyc);
        check("arb1_i_waiting", I_BUSYWAIT, 1'b1);
        check("arb1_d_rdata_kept", D_READDATA, '0);
        D_WRITE = 1'b0; D_READ = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("arb2_mem_read", {MEM_WRITE, MEM_READ}, 2'b01);
        check("arb2_mem_addr_i", MEM_ADDRESS, 28'h8);
        wait_done(1'b1, cyc);
        check("arb2_i_rdata", I_READDATA, {8{16'hBEEF}});
        check("arb2_d_waiting", D_BUSYWAIT, 1'b1);
        I_READ = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("arb3_mem_addr_d", MEM_ADDRESS, 28'h3);
        check("arb3_mem_read", MEM_READ, 1'b1);
        wait_done(1'b0, cyc);
        check("arb3_d_rdata", D_READDATA, W1);
        D_READ = 1'b0;
        @(negedge CLK);

        // Timeout with memory stuck busy: abort after 8 ACCESS cycles.
        stuck = 1'b1;
        D_READ = 1'b1; D_ADDRESS = 28'h9;
        @(posedge CLK);
        @(negedge CLK);
        check("to_strobe_start", MEM_READ, 1'b1);
        for (int k = 1; k < 8; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            check($sformatf("to_wait%0d", k), {MEM_READ, ERROR, D_BUSYWAIT}, 3'b101);
        end
        @(posedge CLK);
        @(negedge CLK);
        check("to_abort", {MEM_READ, ERROR, D_BUSYWAIT}, 3'b010);
        check("to_d_rdata_zero", D_READDATA, '0);
        @(posedge CLK);
        @(negedge CLK);
        check("to_error_pulse_end", {ERROR, D_BUSYWAIT}, 2'b01);
        D_READ = 1'b0;
        stuck = 1'b0;
        @(negedge CLK);

        // Reset during the third ACCESS_D cycle.
        D_WRITE = 1'b1; D_ADDRESS = 28'h2; D_WRITEDATA = W2;
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        check("mr_in_access", MEM_WRITE, 1'b1);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("mr_abandoned", {MEM_READ, MEM_WRITE, ERROR}, 3'b000);
        check("mr_d_busy", D_BUSYWAIT, 1'b1);
        RESET = 1'b1;
        D_WRITE = 1'b0;
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
